// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared state, opcode, ALU-op and select encodings for the RV32 subset core
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7 to ALU operation decode for register and immediate ALU ops
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       is_rtype_i,
    output logic [2:0] alu_control_o,
    output logic       valid_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        valid_o       = 1'b1;
        case (funct3_i)
            // addi has no SUB form, so funct7_5 only matters for register ops
            3'b000:  alu_control_o = (is_rtype_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_control_o = ALU_AND;
            3'b110:  alu_control_o = ALU_OR;
            default: valid_o       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_control
    import cpu_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_t     state_q, state_d;
    logic [2:0] dec_alu;
    logic       dec_valid;

    alu_decoder u_alu_decoder (
        .funct3_i      (funct3),
        .funct7_5_i    (funct7_5),
        .is_rtype_i    (state_q == S_EXECR),
        .alu_control_o (dec_alu),
        .valid_o       (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_control   = ALU_AND;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                alu_src_a   = SRCA_PC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                result_src  = RES_ALU;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // speculative branch target lands in ALUOut for BEQ
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = ALU_ADD;
                state_d     = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = (state_q == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
                alu_control = dec_alu;
                state_d     = dec_valid ? S_ALUWB : S_ILLEGAL;
            end
            S_JAL: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                alu_control = ALU_ADD;
                pc_write    = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = ALU_SUB;
                pc_write    = zero;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_instr = 1'b1;
                state_d       = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // reset must silence the datapath immediately, not one edge later
        if (!resetn) begin
            pc_write      = 1'b0;
            adr_src       = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            result_src    = 2'b00;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            alu_control   = 3'b000;
            illegal_instr = 1'b0;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .illegal_instr(illegal_instr), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       ill;
    } obs_t;

    obs_t exp_q[$];
    bit   dc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t cur();
        return '{state_dbg, pc_write, adr_src, mem_write, ir_write, reg_write,
                 result_src, alu_src_a, alu_src_b, alu_control, illegal_instr};
    endfunction

    function automatic obs_t mk(input state_t st, input logic pcw, adr, mw, irw, rw,
                                input logic [1:0] rs, sa, sb, input logic [2:0] alu,
                                input logic ill);
        return '{st, pcw, adr, mw, irw, rw, rs, sa, sb, alu, ill};
    endfunction

    // Reference: the whole state walk of one instruction, straight from the opcode rules
    function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                  input logic f75, input logic z);
        logic [2:0] alu;
        bit         ok;
        exp_q.delete();
        dc_q.delete();
        exp_q.push_back(mk(S_FETCH, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b010, 0)); dc_q.push_back(0);
        exp_q.push_back(mk(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 0)); dc_q.push_back(0);
        if (op == 7'b0000011 || op == 7'b0100011) begin
            exp_q.push_back(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 0)); dc_q.push_back(0);
            if (op == 7'b0000011) begin
                exp_q.push_back(mk(S_MEMREAD, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)); dc_q.push_back(0);
                exp_q.push_back(mk(S_MEMWB, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0)); dc_q.push_back(0);
            end else begin
                exp_q.push_back(mk(S_MEMWRITE, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0)); dc_q.push_back(0);
            end
        end else if (op == 7'b0110011 || op == 7'b0010011) begin
            ok = 1;
            alu = 3'b000;
            if (f3 == 3'd0) alu = (op == 7'b0110011 && f75) ? 3'b110 : 3'b010;
            else if (f3 == 3'd7) alu = 3'b000;
            else if (f3 == 3'd6) alu = 3'b001;
            else ok = 0;
            exp_q.push_back(mk(op == 7'b0110011 ? S_EXECR : S_EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                               op == 7'b0110011 ? 2'b00 : 2'b01, alu, 0));
            dc_q.push_back(!ok);
            if (ok) exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
            else    exp_q.push_back(mk(S_ILLEGAL, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1));
            dc_q.push_back(0);
        end else if (op == 7'b1101111) begin
            exp_q.push_back(mk(S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b010, 0)); dc_q.push_back(0);
            exp_q.push_back(mk(S_ALUWB, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0)); dc_q.push_back(0);
        end else if (op == 7'b1100011) begin
            exp_q.push_back(mk(S_BEQ, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b110, 0)); dc_q.push_back(0);
        end else begin
            exp_q.push_back(mk(S_ILLEGAL, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1)); dc_q.push_back(0);
        end
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset_enables", {28'd0, pc_write, ir_write, mem_write, reg_write, illegal_instr}, 32'd0);
            @(posedge clk); #1;
        end
        resetn = 1'b1;
    endtask

    // Entered just after a rising edge with the DUT in FETCH
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f75, input logic z, input int hold);
        obs_t a, e;
        build(op, f3, f75, z);
        opcode = op; funct3 = f3; funct7_5 = f75; zero = z;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            a = cur();
            e = exp_q[k];
            if (dc_q[k]) begin a.alu = 3'b000; e.alu = 3'b000; end
            chk($sformatf("%s_step%0d", name, k), 32'(a), 32'(e));
            chk($sformatf("%s_exclusive%0d", name, k),
                {30'd0, mem_write & reg_write, pc_write & mem_write}, 32'd0);
            @(posedge clk); #1;
        end
        if (exp_q[exp_q.size()-1].ill) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk($sformatf("%s_trap%0d", name, h), {27'd0, illegal_instr, state_dbg},
                    {27'd1, 4'(S_ILLEGAL)});
                @(posedge clk); #1;
            end
            do_reset();
        end else begin
            chk($sformatf("%s_back_to_fetch", name), 32'(state_dbg), 32'(S_FETCH));
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f75;
        logic       z;
        int         cycles;
        int         pcw_cnt;
        int         rw_cnt;
        int         mw_cnt;
        logic [2:0] alu3;
    } vec_t;

    // Counts DUT activity from FETCH until it is back in FETCH
    task automatic measure(input vec_t v);
        int cyc, pcw, rw, mw;
        logic [2:0] alu3;
        cyc = 0; pcw = 0; rw = 0; mw = 0; alu3 = 3'b111;
        opcode = v.op; funct3 = v.f3; funct7_5 = v.f75; zero = v.z;
        do begin
            @(negedge clk);
            if (cyc == 2) alu3 = alu_control;
            pcw += int'(pc_write); rw += int'(reg_write); mw += int'(mem_write);
            cyc++;
            @(posedge clk); #1;
        end while (state_dbg != 4'(S_FETCH) && cyc < 20);
        chk({v.name, "_cycles"}, 32'(cyc), 32'(v.cycles));
        chk({v.name, "_counts"}, {8'd0, 8'(pcw), 8'(rw), 8'(mw)},
            {8'd0, 8'(v.pcw_cnt), 8'(v.rw_cnt), 8'(v.mw_cnt)});
        chk({v.name, "_alu3"}, 32'(alu3), 32'(v.alu3));
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{"add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4, 1, 1, 0, 3'b010});
        vecs.push_back('{"sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1, 1, 0, 3'b110});
        vecs.push_back('{"and",  7'b0110011, 3'b111, 1'b0, 1'b0, 4, 1, 1, 0, 3'b000});
        vecs.push_back('{"ori",  7'b0010011, 3'b110, 1'b0, 1'b0, 4, 1, 1, 0, 3'b001});
        vecs.push_back('{"addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 1, 1, 0, 3'b010});
        vecs.push_back('{"lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 5, 1, 1, 0, 3'b010});
        vecs.push_back('{"sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 4, 1, 0, 1, 3'b010});
        vecs.push_back('{"jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4, 2, 1, 0, 3'b010});
        vecs.push_back('{"beq1", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 2, 0, 0, 3'b110});
        vecs.push_back('{"beq0", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 1, 0, 0, 3'b110});

        do_reset();

        // Reset state then a full add walk
        run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0);
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 0);
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 0);
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 0);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 0);
        run_instr("beq_not", 7'b1100011, 3'b000, 1'b0, 1'b0, 0);

        foreach (vecs[i]) measure(vecs[i]);

        // Illegal opcode parks the FSM; an invalid R-type funct3 traps from EXECR
        run_instr("lui_illegal", 7'b0110111, 3'b000, 1'b0, 1'b0, 10);
        run_instr("r_f3_010", 7'b0110011, 3'b010, 1'b0, 1'b0, 3);

        // Reset while storing: the write must not survive the reset edge
        build(7'b0100011, 3'b010, 1'b0, 1'b0);
        opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("swrst_step%0d", k), 32'(cur()), 32'(exp_q[k]));
            if (k < 3) begin @(posedge clk); #1; end
        end
        resetn = 1'b0;
        #1;
        chk("swrst_mw_forced_low", 32'(mem_write), 32'd0);
        @(posedge clk); #1;
        chk("swrst_after_edge", {27'd0, mem_write, state_dbg}, {27'd0, 4'(S_FETCH)});
        resetn = 1'b1;
        run_instr("post_reset_add", 7'b0110011, 3'b000, 1'b0, 1'b0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2, 7: op = 7'b0110011;
                3, 8: op = 7'b0010011;
                4: op = 7'b1101111;
                5: op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: f3 = 3'b000;
                1: f3 = 3'b111;
                2: f3 = 3'b110;
                default: f3 = 3'($urandom);
            endcase
            run_instr($sformatf("rnd%0d", n), op, f3, 1'($urandom), 1'($urandom),
                      $urandom_range(1, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
